// File: rtl/fibo_pkg.sv
// -----------------------------------------------------------------------------
// fibo_pkg
// Shared definitions for the Fibonacci datapath:
//   - micro-op opcode encodings (OP_NOP .. OP_TST)
//   - register-file geometry (REG_ADDR_W, NUM_REGS)
//   - result-capture FSM state encoding
// -----------------------------------------------------------------------------
package fibo_pkg;

  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 4;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_CLR = 3'b100;
  localparam logic [2:0] OP_DEC = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_TST = 3'b111;

  typedef enum logic [0:0] {
    CAP_IDLE = 1'b0,
    CAP_HOLD = 1'b1
  } cap_state_t;

endpackage

// File: rtl/fibo_alu.sv
// -----------------------------------------------------------------------------
// fibo_alu
// Combinational micro-op ALU for the Fibonacci datapath.
// Optional build macro: FIBO_DP_SAT_EN (ADD/INC saturate at all-ones, DEC
// saturates at zero; overflow is still reported). Default build wraps.
// Ports:
//   i_opcode  micro-op select
//   i_a       value of R[operand1] (destination / first source)
//   i_b       value of R[operand2] (second source)
//   i_data    immediate for LDI
//   o_result  value to write into R[operand1]
//   o_we      register write enable (0 for NOP and TST)
//   o_zero    new zero-flag value (meaningful for every opcode except NOP)
//   o_ovf     carry out of ADD/INC, or DEC applied to zero
// -----------------------------------------------------------------------------
module fibo_alu
  import fibo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_result,
  output logic             o_we,
  output logic             o_zero,
  output logic             o_ovf
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_a_zero;
  logic             w_tst_eq;

  // Widened adders so the carry out of the top bit is visible.
  assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
  assign w_inc    = {1'b0, i_a} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec    = i_a - {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_a_zero = (i_a == {WIDTH{1'b0}});
  assign w_tst_eq = (i_a == i_b);

  // Opcode decode: result, write enable, overflow and zero flag.
  always_comb begin
    o_result = {WIDTH{1'b0}};
    o_we     = 1'b0;
    o_ovf    = 1'b0;
    o_zero   = 1'b0;
    case (i_opcode)
      OP_NOP: begin
        o_we = 1'b0;
      end
      OP_LDI: begin
        o_result = i_data;
        o_we     = 1'b1;
      end
      OP_MOV: begin
        o_result = i_b;
        o_we     = 1'b1;
      end
      OP_ADD: begin
        o_ovf = w_sum[WIDTH];
        o_we  = 1'b1;
`ifdef FIBO_DP_SAT_EN
        o_result = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
        o_result = w_sum[WIDTH-1:0];
`endif
      end
      OP_CLR: begin
        o_result = {WIDTH{1'b0}};
        o_we     = 1'b1;
      end
      OP_DEC: begin
        o_ovf = w_a_zero;
        o_we  = 1'b1;
`ifdef FIBO_DP_SAT_EN
        o_result = w_a_zero ? {WIDTH{1'b0}} : w_dec;
`else
        o_result = w_dec;
`endif
      end
      OP_INC: begin
        o_ovf = w_inc[WIDTH];
        o_we  = 1'b1;
`ifdef FIBO_DP_SAT_EN
        o_result = w_inc[WIDTH] ? {WIDTH{1'b1}} : w_inc[WIDTH-1:0];
`else
        o_result = w_inc[WIDTH-1:0];
`endif
      end
      OP_TST: begin
        o_we = 1'b0;
      end
      default: begin
        o_we = 1'b0;
      end
    endcase
    // Writing ops flag the value actually written (post-saturation);
    // TST compares its two sources without writing.
    o_zero = o_we ? (o_result == {WIDTH{1'b0}}) : ((i_opcode == OP_TST) && w_tst_eq);
  end

endmodule

// File: rtl/fibo_datapath.sv
// -----------------------------------------------------------------------------
// fibo_datapath
// Register file (R0..R3) plus ALU, executing one micro-op per cycle from the
// Fibonacci controller, with a sticky overflow flag and a result-capture FSM
// that latches R[operand1] on the rising edge of DONE.
// Optional build macro: FIBO_DP_SAT_EN (saturating arithmetic in fibo_alu).
// Ports:
//   CLK           system clock
//   RST           synchronous active-high reset
//   opcode        micro-op select
//   operand1      register address A (destination and first source)
//   operand2      register address B (second source)
//   DONE          controller completion strobe
//   DATA_IN       LDI immediate
//   ZERO_FLAG     registered zero flag
//   OVF           sticky overflow/underflow flag
//   RESULT        captured final value
//   RESULT_VALID  RESULT holds a captured value (DONE still high)
// -----------------------------------------------------------------------------
module fibo_datapath
  import fibo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2:0]            opcode,
  input  logic [REG_ADDR_W-1:0] operand1,
  input  logic [REG_ADDR_W-1:0] operand2,
  input  logic                  DONE,
  input  logic [WIDTH-1:0]      DATA_IN,
  output logic                  ZERO_FLAG,
  output logic                  OVF,
  output logic [WIDTH-1:0]      RESULT,
  output logic                  RESULT_VALID
);

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             r_zero;
  logic             r_ovf;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_done_q;
  cap_state_t       r_state;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_we;
  logic             w_alu_zero;
  logic             w_alu_ovf;
  cap_state_t       w_state_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_result_valid_nxt;

  // Reads see register contents from before this cycle's write (no bypass).
  assign w_a = r_regs[operand1];
  assign w_b = r_regs[operand2];

  fibo_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_opcode (opcode),
    .i_a      (w_a),
    .i_b      (w_b),
    .i_data   (DATA_IN),
    .o_result (w_alu_result),
    .o_we     (w_alu_we),
    .o_zero   (w_alu_zero),
    .o_ovf    (w_alu_ovf)
  );

  // Register file, zero flag and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_alu_we) begin
        r_regs[operand1] <= w_alu_result;
      end
      // NOP is the only op that leaves the zero flag untouched.
      if (opcode != OP_NOP) begin
        r_zero <= w_alu_zero;
      end
      if (w_alu_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Capture FSM next state: latch R[operand1] on the DONE rising edge.
  always_comb begin
    w_state_nxt        = r_state;
    w_result_nxt       = r_result;
    w_result_valid_nxt = r_result_valid;
    case (r_state)
      CAP_IDLE: begin
        if (DONE && !r_done_q) begin
          w_state_nxt        = CAP_HOLD;
          w_result_nxt       = w_a;
          w_result_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = CAP_IDLE;
        end
      end
      CAP_HOLD: begin
        if (!DONE) begin
          w_state_nxt        = CAP_IDLE;
          w_result_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = CAP_HOLD;
        end
      end
      default: begin
        w_state_nxt        = CAP_IDLE;
        w_result_valid_nxt = 1'b0;
      end
    endcase
  end

  // Capture FSM state, captured result and registered copy of DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= CAP_IDLE;
      r_result       <= {WIDTH{1'b0}};
      r_result_valid <= 1'b0;
      r_done_q       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_done_q       <= DONE;
    end
  end

  assign ZERO_FLAG    = r_zero;
  assign OVF          = r_ovf;
  assign RESULT       = r_result;
  assign RESULT_VALID = r_result_valid;

endmodule
